// File: rtl/bus_arb_pkg.sv
// Shared types and sizing helpers for the round-robin bus arbiter.
package bus_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    OWNED,
    TURN
  } arb_state_t;

  // Bits needed to count 0..max_val, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val == 0) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/bus_arbiter_if.sv
// Request/grant handshake between the masters and the bus arbiter.
interface bus_arbiter_if #(
  parameter int MASTERS    = 2,
  parameter int M_ID_WIDTH = $clog2(MASTERS)
);

  logic [MASTERS-1:0]    req;
  logic [MASTERS-1:0]    done;
  logic [MASTERS-1:0]    grant;
  logic [M_ID_WIDTH-1:0] grant_id;
  logic                  bus_busy;
  logic                  preempt;

  modport master (
    output req, done,
    input  grant, grant_id, bus_busy, preempt
  );

  modport slave (
    input  req, done,
    output grant, grant_id, bus_busy, preempt
  );

endinterface

// File: rtl/bus_arbiter_rr_picker.sv
// Combinational round-robin selector: first requester at or above rr_ptr, wrapping.
module rr_picker #(
  parameter int MASTERS    = 2,
  parameter int M_ID_WIDTH = $clog2(MASTERS)
) (
  input  logic [MASTERS-1:0]    req,
  input  logic [M_ID_WIDTH-1:0] rr_ptr,
  output logic                  any,
  output logic [M_ID_WIDTH-1:0] sel
);

  always_comb begin
    int unsigned idx;
    logic [M_ID_WIDTH-1:0] idx_s;
    any   = 1'b0;
    sel   = '0;
    idx   = 0;
    idx_s = '0;
    for (int unsigned i = 0; i < MASTERS; i++) begin
      idx   = (32'(rr_ptr) + i) % MASTERS;
      idx_s = M_ID_WIDTH'(idx);
      if (!any && req[idx_s]) begin
        any = 1'b1;
        sel = idx_s;
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin serial-bus arbiter with turnaround gap and optional hold-time pre-emption.
module bus_arbiter
  import bus_arb_pkg::*;
#(
  parameter int MASTERS     = 2,
  parameter int M_ID_WIDTH  = $clog2(MASTERS),
  parameter int MAX_HOLD    = 256,
  parameter int TURN_CYCLES = 1
) (
  input logic           clk,
  input logic           rstN,
  bus_arbiter_if.slave  arb
);

  localparam int unsigned HOLD_W    = cnt_width(MAX_HOLD);
  localparam int unsigned TURN_W    = $clog2(TURN_CYCLES + 1);
  localparam int unsigned HOLD_LAST = (MAX_HOLD == 0) ? 0 : MAX_HOLD - 1;

  arb_state_t            state;
  logic [MASTERS-1:0]    grant_r;
  logic [M_ID_WIDTH-1:0] grant_id_r;
  logic [M_ID_WIDTH-1:0] rr_ptr;
  logic [HOLD_W-1:0]     hold_cnt;
  logic [TURN_W-1:0]     turn_cnt;
  logic                  bus_busy_r;
  logic                  preempt_r;

  logic                  pick_any;
  logic [M_ID_WIDTH-1:0] pick_sel;
  logic [MASTERS-1:0]    owner_mask;
  logic                  owner_done;
  logic                  owner_req;
  logic                  others_req;
  logic                  timeout;
  logic                  release_bus;
  logic [M_ID_WIDTH-1:0] next_ptr;

  rr_picker #(
    .MASTERS   (MASTERS),
    .M_ID_WIDTH(M_ID_WIDTH)
  ) u_picker (
    .req   (arb.req),
    .rr_ptr(rr_ptr),
    .any   (pick_any),
    .sel   (pick_sel)
  );

  assign owner_mask  = MASTERS'(1) << grant_id_r;
  assign owner_done  = arb.done[grant_id_r];
  assign owner_req   = arb.req[grant_id_r];
  assign others_req  = |(arb.req & ~owner_mask);
  // hold_cnt saturates at MAX_HOLD, so the timeout window is the single cycle at MAX_HOLD-1
  assign timeout     = (MAX_HOLD != 0) && (hold_cnt == HOLD_W'(HOLD_LAST)) && others_req;
  assign release_bus = owner_done || !owner_req || timeout;
  assign next_ptr    = (grant_id_r == M_ID_WIDTH'(MASTERS - 1)) ? '0
                                                                : grant_id_r + M_ID_WIDTH'(1);

  always_ff @(posedge clk) begin
    if (!rstN) begin
      state      <= IDLE;
      grant_r    <= '0;
      grant_id_r <= '0;
      rr_ptr     <= '0;
      hold_cnt   <= '0;
      turn_cnt   <= '0;
      bus_busy_r <= 1'b0;
      preempt_r  <= 1'b0;
    end else begin
      preempt_r <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_any) begin
            grant_r    <= MASTERS'(1) << pick_sel;
            grant_id_r <= pick_sel;
            bus_busy_r <= 1'b1;
            hold_cnt   <= '0;
            state      <= OWNED;
          end
        end
        OWNED: begin
          if (release_bus) begin
            grant_r    <= '0;
            bus_busy_r <= 1'b0;
            rr_ptr     <= next_ptr;
            turn_cnt   <= '0;
            preempt_r  <= timeout && !owner_done && owner_req;
            state      <= TURN;
          end else if (hold_cnt != HOLD_W'(MAX_HOLD)) begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
          end
        end
        TURN: begin
          if (turn_cnt == TURN_W'(TURN_CYCLES - 1)) begin
            state <= IDLE;
          end else begin
            turn_cnt <= turn_cnt + TURN_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign arb.grant    = grant_r;
  assign arb.grant_id = grant_id_r;
  assign arb.bus_busy = bus_busy_r;
  assign arb.preempt  = preempt_r;

  a_grant_onehot: assert property (@(posedge clk) $onehot0(grant_r));
  a_busy_match:   assert property (@(posedge clk) bus_busy_r == (|grant_r));
  a_ptr_range:    assert property (@(posedge clk) 32'(rr_ptr) < MASTERS);

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench: two arbiter configurations against an ownership/timeline model.
module tb_bus_arbiter;

  localparam int M = 2;

  logic clk = 1'b0;
  logic rstN;
  always #5 clk = ~clk;

  bus_arbiter_if #(.MASTERS(M)) ifa ();
  bus_arbiter_if #(.MASTERS(M)) ifb ();

  bus_arbiter #(.MASTERS(M), .MAX_HOLD(16), .TURN_CYCLES(1)) dut_a (
    .clk (clk),
    .rstN(rstN),
    .arb (ifa.slave)
  );

  bus_arbiter #(.MASTERS(M), .MAX_HOLD(0), .TURN_CYCLES(3)) dut_b (
    .clk (clk),
    .rstN(rstN),
    .arb (ifb.slave)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  // Model: who owns the bus, since which cycle, how many gap cycles remain, who is next in line.
  int cfg_hold[2] = '{16, 0};
  int cfg_turn[2] = '{1, 3};
  int m_owner[2]  = '{-1, -1};
  int m_start[2]  = '{0, 0};
  int m_gap[2]    = '{0, 0};
  int m_next[2]   = '{0, 0};
  int m_last[2]   = '{0, 0};
  int m_pre[2]    = '{0, 0};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic model_step(input logic [M-1:0] r, input logic [M-1:0] d, input logic rs);
    for (int k = 0; k < 2; k++) begin
      if (!rs) begin
        m_owner[k] = -1; m_gap[k] = 0; m_next[k] = 0; m_last[k] = 0; m_pre[k] = 0;
      end else begin
        m_pre[k] = 0;
        if (m_owner[k] >= 0) begin
          int o, held;
          bit others, to, rel;
          o      = m_owner[k];
          held   = cyc - m_start[k];
          others = 1'b0;
          for (int j = 0; j < M; j++) if (j != o && r[j]) others = 1'b1;
          to  = (cfg_hold[k] > 0) && (held == cfg_hold[k] - 1) && others;
          rel = d[o] || !r[o] || to;
          if (rel) begin
            m_pre[k]   = (to && !d[o] && r[o]) ? 1 : 0;
            m_next[k]  = (o + 1) % M;
            m_owner[k] = -1;
            m_gap[k]   = cfg_turn[k];
          end
        end else if (m_gap[k] > 0) begin
          m_gap[k]--;
        end else begin
          for (int i = 0; i < M; i++) begin
            int c;
            c = (m_next[k] + i) % M;
            if (m_owner[k] < 0 && r[c]) begin
              m_owner[k] = c;
              m_last[k]  = c;
              m_start[k] = cyc + 1;
            end
          end
        end
      end
    end
    cyc++;
  endtask

  task automatic compare_all();
    for (int k = 0; k < 2; k++) begin
      logic [M-1:0] g, eg;
      logic [31:0]  gid;
      logic         busy, pre;
      g    = (k == 0) ? ifa.grant    : ifb.grant;
      gid  = (k == 0) ? 32'(ifa.grant_id) : 32'(ifb.grant_id);
      busy = (k == 0) ? ifa.bus_busy : ifb.bus_busy;
      pre  = (k == 0) ? ifa.preempt  : ifb.preempt;
      eg   = (m_owner[k] >= 0) ? (M'(1) << m_owner[k]) : '0;
      chk($sformatf("grant[%0d]", k), 32'(g), 32'(eg));
      chk($sformatf("grant_id[%0d]", k), gid, 32'(m_last[k]));
      chk($sformatf("bus_busy[%0d]", k), 32'(busy), (m_owner[k] >= 0) ? 32'd1 : 32'd0);
      chk($sformatf("preempt[%0d]", k), 32'(pre), 32'(m_pre[k]));
    end
  endtask

  task automatic tick(input logic [M-1:0] r, input logic [M-1:0] d, input logic rs);
    ifa.req  = r; ifb.req  = r;
    ifa.done = d; ifb.done = d;
    rstN     = rs;
    model_step(r, d, rs);
    @(negedge clk);
    compare_all();
  endtask

  initial begin
    int pre_b_seen, bad_b, n_gr, zeros;
    int seq[4];
    int gaps[4];
    logic [M-1:0] prev_g, rq, dn;

    ifa.req = '0; ifb.req = '0; ifa.done = '0; ifb.done = '0; rstN = 1'b0;
    @(negedge clk);
    tick(2'b00, 2'b00, 1'b0);
    tick(2'b00, 2'b00, 1'b0);

    // Single requester: grant one cycle after req, release on done, regrant after the gap
    tick(2'b01, 2'b00, 1'b1);
    chk("single_grant", 32'(ifa.grant), 32'h1);
    chk("single_id", 32'(ifa.grant_id), 32'h0);
    chk("single_busy", 32'(ifa.bus_busy), 32'h1);
    for (int c = 1; c <= 9; c++) tick(2'b01, 2'b00, 1'b1);
    tick(2'b01, 2'b01, 1'b1);
    chk("done_release", 32'(ifa.grant), 32'h0);
    tick(2'b01, 2'b00, 1'b1);
    chk("turn_gap", 32'(ifa.grant), 32'h0);
    tick(2'b01, 2'b00, 1'b1);
    chk("regrant", 32'(ifa.grant), 32'h1);

    // Pre-emption: owner from cycle 13, competitor from cycle 16, timeout on 16th owned cycle
    for (int c = 13; c <= 15; c++) tick(2'b01, 2'b00, 1'b1);
    for (int c = 16; c <= 27; c++) tick(2'b11, 2'b00, 1'b1);
    chk("hold_16th", 32'(ifa.grant), 32'h1);
    chk("hold_16th_nopre", 32'(ifa.preempt), 32'h0);
    tick(2'b11, 2'b00, 1'b1);
    chk("preempt_pulse", 32'(ifa.preempt), 32'h1);
    chk("preempt_drop", 32'(ifa.grant), 32'h0);
    chk("no_timeout_b", 32'(ifb.grant), 32'h1);
    tick(2'b11, 2'b00, 1'b1);
    chk("preempt_one_cycle", 32'(ifa.preempt), 32'h0);
    chk("preempt_gap", 32'(ifa.grant), 32'h0);
    tick(2'b11, 2'b00, 1'b1);
    chk("rr_next", 32'(ifa.grant), 32'h2);
    chk("rr_next_id", 32'(ifa.grant_id), 32'h1);

    // done from a non-owner is ignored
    tick(2'b11, 2'b00, 1'b1);
    tick(2'b11, 2'b01, 1'b1);
    chk("ignored_done", 32'(ifa.grant), 32'h2);

    // done[owner] coincides with timeout: release without preempt
    for (int c = 33; c <= 45; c++) tick(2'b11, 2'b00, 1'b1);
    tick(2'b11, 2'b10, 1'b1);
    chk("simul_release", 32'(ifa.grant), 32'h0);
    chk("simul_nopreempt", 32'(ifa.preempt), 32'h0);

    // Reset during master 1's ownership
    tick(2'b10, 2'b00, 1'b1);
    tick(2'b10, 2'b00, 1'b1);
    chk("pre_reset_owner", 32'(ifa.grant), 32'h2);
    tick(2'b10, 2'b00, 1'b0);
    chk("reset_grant", 32'(ifa.grant), 32'h0);
    chk("reset_busy", 32'(ifa.bus_busy), 32'h0);
    chk("reset_id", 32'(ifa.grant_id), 32'h0);
    tick(2'b11, 2'b00, 1'b1);
    chk("reset_first_m0", 32'(ifa.grant), 32'h1);

    // MAX_HOLD=0: master 0 keeps the bus while master 1 waits
    pre_b_seen = 0;
    bad_b      = 0;
    repeat (1000) begin
      tick(2'b11, 2'b00, 1'b1);
      if (ifb.preempt) pre_b_seen++;
      if (ifb.grant != 2'b01) bad_b++;
    end
    chk("nohold_preempt_count", 32'(pre_b_seen), 32'h0);
    chk("nohold_lost_grant", 32'(bad_b), 32'h0);

    // Fairness: both request, owner signals done on its 8th owned cycle
    tick(2'b00, 2'b00, 1'b0);
    n_gr   = 0;
    zeros  = 0;
    prev_g = '0;
    for (int t = 0; t < 120 && n_gr < 4; t++) begin
      dn = '0;
      if (m_owner[0] >= 0 && (cyc - m_start[0]) == 7) dn = M'(1) << m_owner[0];
      tick(2'b11, dn, 1'b1);
      if (ifa.grant == '0) zeros++;
      else if (prev_g == '0) begin
        seq[n_gr]  = int'(ifa.grant_id);
        gaps[n_gr] = zeros;
        zeros      = 0;
        n_gr++;
      end
      prev_g = ifa.grant;
    end
    chk("fair_count", 32'(n_gr), 32'd4);
    for (int i = 0; i < 4 && i < n_gr; i++) begin
      chk($sformatf("fair_order%0d", i), 32'(seq[i]), 32'(i % 2));
      if (i > 0) chk($sformatf("fair_gap%0d", i), 32'(gaps[i]), 32'd2);
    end

    // Random traffic with occasional reset
    rq = '0;
    repeat (3000) begin
      for (int j = 0; j < M; j++) begin
        if (rq[j]) rq[j] = ($urandom_range(0, 15) != 0);
        else       rq[j] = ($urandom_range(0, 3) == 0);
      end
      dn = '0;
      for (int j = 0; j < M; j++) dn[j] = ($urandom_range(0, 11) == 0);
      tick(rq, dn, ($urandom_range(0, 399) != 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
Round-robin arbiter that shares the serial bus (control/wD/valid/last toward slaves, rD/ready back) between MASTERS requesting masters. It sits at the front of the interconnect. It issues a one-hot grant that the interconnect uses to steer the granted master's serial lines to the slaves. It enforces a turnaround gap between owners and optionally pre-empts a master that holds the bus too long while others wait.

Parameters:
MASTERS, 2, number of requesting masters (must be >= 2)
M_ID_WIDTH, $clog2(MASTERS), width of the encoded grant index
MAX_HOLD, 256, cycles a master may hold the bus before pre-emption if another master is waiting; 0 disables pre-emption
TURN_CYCLES, 1, idle cycles with no grant between two bus owners (>= 1)

Ports:
clk  input  1  system clock
rstN  input  1  synchronous active-low reset
req  input  MASTERS  per-master bus request, level; held high until released
done  input  MASTERS  per-master one-cycle pulse: transfer complete (after last/final bit)
grant  output  MASTERS  one-hot grant; all zero when bus is free or in turnaround
grant_id  output  M_ID_WIDTH  encoded index of current or most recent owner
bus_busy  output  1  high while any grant is asserted
preempt  output  1  one-cycle pulse when a grant is revoked by timeout

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-low (rstN).
- Reset (rstN low at a clk edge): grant=0, grant_id=0, bus_busy=0, preempt=0, rr_ptr=0, hold_cnt=0, turn_cnt=0, state=IDLE. Reset asserted mid-grant drops the grant on that edge. The arbiter issues no end-of-transfer cleanup; slaves recover on their own reset.
- State machine, states IDLE, OWNED, TURN:
- IDLE:
  - If req != 0, pick the first requester searching upward from rr_ptr with wrap-around (rr_ptr has highest priority).
  - Next edge: grant[sel]=1, grant_id=sel, bus_busy=1, hold_cnt=0, go to OWNED. Latency is 1 cycle from req seen to grant.
  - If req == 0, remain in IDLE with outputs at rest.
- OWNED:
  - hold_cnt increments each cycle and saturates at MAX_HOLD.
  - Release condition: done[grant_id] is 1, OR req[grant_id] is 0, OR pre-emption fires.
  - Pre-emption fires when MAX_HOLD != 0, hold_cnt == MAX_HOLD-1, and any other req bit is high.
  - On release: grant=0, bus_busy=0, rr_ptr=(grant_id+1) mod MASTERS, turn_cnt=0, go to TURN.
  - preempt=1 for exactly that cycle only when pre-emption was the sole release cause. If done or req-drop coincides with the timeout, preempt stays 0.
  - done bits from non-granted masters are ignored. Multiple done bits are ignored except done[grant_id].
- TURN:
  - grant stays 0 for TURN_CYCLES cycles (turn_cnt counts 0..TURN_CYCLES-1), then go to IDLE.
  - Requests arriving during TURN are held by the masters, not latched.
  - The arbiter enforces no same-master back-to-back priority: the released owner sits at the lowest priority through rr_ptr.
- Minimum gap between two grants is TURN_CYCLES+1 cycles: TURN, then the IDLE decision cycle.
- A master whose req is still high after release competes normally. If it is the only requester, it is re-granted after the gap.
- Width rules:
  - hold_cnt is $clog2(MAX_HOLD+1) bits, minimum 1.
  - turn_cnt is $clog2(TURN_CYCLES+1) bits.
  - rr_ptr wraps from MASTERS-1 to 0 and never holds a value >= MASTERS.
- Invariants: grant is always one-hot or zero. bus_busy == |grant.

Decomposition:
- Package bus_arb_pkg: state enum arb_state_t {IDLE, OWNED, TURN}.
- Sub-module rr_picker: purely combinational, (req, rr_ptr) -> (any, sel index). It is instantiated once.
- Sequencing, counters and outputs live in bus_arbiter.

Test Plan:
- Single requester: req=2'b01 at cycle 0 -> grant=2'b01 at cycle 1, grant_id=0, bus_busy=1. done[0] pulse at cycle 10 -> grant=0 at cycle 11, grant=2'b01 again no earlier than cycle 13 if req is still high.
- Fairness: req=2'b11 held with done pulses every 8 cycles of ownership -> grants alternate 0,1,0,1. Each gap between grants is exactly 2 cycles (TURN_CYCLES=1).
- Pre-emption: MAX_HOLD=16, master 0 owns the bus with no done, req[1] rises at cycle 3 -> grant[0] drops and preempt=1 for one cycle at the 16th owned cycle. grant=2'b10 follows after the turnaround.
- Ignored done and no timeout: done[1] pulsed while master 0 owns -> no change. With MAX_HOLD=0 and master 1 waiting for 1000 cycles -> grant[0] held and preempt never asserted.
- Reset mid-operation: rstN low for one edge during OWNED -> next cycle grant=0, bus_busy=0, grant_id=0, rr_ptr=0. With req=2'b11 after reset, master 0 is granted first.
- Simultaneous release: done[0] and the timeout in the same cycle -> grant drops and preempt stays 0.
